// File: rtl/decoder_pkg.sv
// Shared types and sizing helpers for the CIM filter-decoder pass scheduler.
// Optional watchdog is enabled in decoder_sched by defining DECODER_WATCHDOG_EN.
package decoder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int f_bit_out_ch(input int out_ch);
        return $clog2(out_ch);
    endfunction

    function automatic int f_slots(input int num_macro, input int max_num_filter);
        return num_macro * max_num_filter;
    endfunction

    function automatic int f_num_pass(input int n, input int slots);
        return (n + slots - 1) / slots;
    endfunction

endpackage

// File: rtl/decoder_slot_map.sv
// Combinational map from (pass, filter count) to the WHICH_FILTER word and
// per-slot valid mask; the caller registers the result.
module decoder_slot_map
    import decoder_pkg::*;
#(
    parameter int NUM_MACRO      = 1,
    parameter int MAX_NUM_FILTER = 1,
    parameter int OUT_CH         = 64
) (
    input  logic [$clog2(OUT_CH):0]                              pass,
    input  logic [$clog2(OUT_CH):0]                              n,
    output logic [NUM_MACRO*MAX_NUM_FILTER*$clog2(OUT_CH)-1:0]   which_filter,
    output logic [NUM_MACRO*MAX_NUM_FILTER-1:0]                  slot_valid
);

    localparam int BIT_OUT_CH = f_bit_out_ch(OUT_CH);
    localparam int SLOTS      = f_slots(NUM_MACRO, MAX_NUM_FILTER);

    logic [31:0] f_s;

    // Slot s of pass p carries filter p*SLOTS+s when that index is inside the job.
    always_comb begin
        which_filter = {(SLOTS*BIT_OUT_CH){1'b0}};
        slot_valid   = {SLOTS{1'b0}};
        f_s          = 32'd0;
        for (int s = 0; s < SLOTS; s++) begin
            f_s = 32'(pass) * 32'(SLOTS) + 32'(s);
            if (f_s < 32'(n)) begin
                which_filter[s*BIT_OUT_CH +: BIT_OUT_CH] = f_s[BIT_OUT_CH-1:0];
                slot_valid[s]                            = 1'b1;
            end else begin
                which_filter[s*BIT_OUT_CH +: BIT_OUT_CH] = {BIT_OUT_CH{1'b0}};
                slot_valid[s]                            = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_sched.sv
// Pass scheduler: splits a filter job into decoder passes and hands each to the
// accumulator. Define DECODER_WATCHDOG_EN to add the WAIT-state watchdog and err.
module decoder_sched
    import decoder_pkg::*;
#(
    parameter int NUM_MACRO      = 1,
    parameter int MAX_NUM_FILTER = 1,
    parameter int OUT_CH         = 64,
    parameter int WD_CYCLES      = 16
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                start,
    input  logic [$clog2(OUT_CH):0]                             cfg_num_filter,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                dec_in_valid,
    output logic [NUM_MACRO*MAX_NUM_FILTER*$clog2(OUT_CH)-1:0]  dec_which_filter,
    input  logic                                                dec_out_valid,
    output logic [NUM_MACRO*MAX_NUM_FILTER-1:0]                 slot_valid,
    output logic [$clog2(OUT_CH):0]                             pass_idx,
    output logic                                                acc_valid,
    input  logic                                                acc_ready,
    output logic                                                acc_last,
    output logic                                                err
);

    localparam int BIT_OUT_CH = f_bit_out_ch(OUT_CH);
    localparam int SLOTS      = f_slots(NUM_MACRO, MAX_NUM_FILTER);
    localparam int CW         = BIT_OUT_CH + 1;
    localparam int FW         = SLOTS * BIT_OUT_CH;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   n_r, n_nxt_s, pass_r, pass_nxt_s, clamp_s;
    logic            last_s, timeout_s;
    logic [FW-1:0]   map_which_s, which_r, which_nxt_s;
    logic [SLOTS-1:0] map_valid_s, slot_valid_r, slot_valid_nxt_s;
    logic [CW-1:0]   pass_idx_r, pass_idx_nxt_s;
    logic            busy_r, busy_nxt_s, done_r, done_nxt_s;
    logic            in_valid_r, in_valid_nxt_s, acc_valid_r, acc_valid_nxt_s;
    logic            acc_last_r, acc_last_nxt_s;

    assign clamp_s = (cfg_num_filter > CW'(OUT_CH)) ? CW'(OUT_CH) : cfg_num_filter;
    // Avoids a divider: this pass is last once its slots cover every filter.
    assign last_s  = ((32'(pass_r) + 32'd1) * 32'(SLOTS)) >= 32'(n_r);

    // Mapping is computed for the pass about to be issued so it lands registered.
    decoder_slot_map #(
        .NUM_MACRO      (NUM_MACRO),
        .MAX_NUM_FILTER (MAX_NUM_FILTER),
        .OUT_CH         (OUT_CH)
    ) u_slot_map (
        .pass         (pass_nxt_s),
        .n            (n_nxt_s),
        .which_filter (map_which_s),
        .slot_valid   (map_valid_s)
    );

    // State, job context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            n_r          <= {CW{1'b0}};
            pass_r       <= {CW{1'b0}};
            which_r      <= {FW{1'b0}};
            slot_valid_r <= {SLOTS{1'b0}};
            pass_idx_r   <= {CW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            in_valid_r   <= 1'b0;
            acc_valid_r  <= 1'b0;
            acc_last_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            n_r          <= n_nxt_s;
            pass_r       <= pass_nxt_s;
            which_r      <= which_nxt_s;
            slot_valid_r <= slot_valid_nxt_s;
            pass_idx_r   <= pass_idx_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            in_valid_r   <= in_valid_nxt_s;
            acc_valid_r  <= acc_valid_nxt_s;
            acc_last_r   <= acc_last_nxt_s;
        end
    end

    // Next-state and job-context update.
    always_comb begin
        state_nxt_s = state_r;
        n_nxt_s     = n_r;
        pass_nxt_s  = pass_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    n_nxt_s     = clamp_s;
                    pass_nxt_s  = {CW{1'b0}};
                    state_nxt_s = (clamp_s != {CW{1'b0}}) ? ISSUE : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (dec_out_valid) begin
                    state_nxt_s = ACC;
                end else if (timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            ACC: begin
                if (acc_ready) begin
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ISSUE;
                        pass_nxt_s  = pass_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        busy_nxt_s      = (state_nxt_s == ISSUE) || (state_nxt_s == WAIT) || (state_nxt_s == ACC);
        done_nxt_s      = (state_nxt_s == DONE);
        in_valid_nxt_s  = (state_nxt_s == ISSUE);
        acc_valid_nxt_s = (state_nxt_s == ACC);
        acc_last_nxt_s  = (state_nxt_s == ACC) && last_s;
        case (state_nxt_s)
            ISSUE: begin
                which_nxt_s      = map_which_s;
                slot_valid_nxt_s = map_valid_s;
                pass_idx_nxt_s   = pass_nxt_s;
            end
            WAIT, ACC: begin
                which_nxt_s      = which_r;
                slot_valid_nxt_s = slot_valid_r;
                pass_idx_nxt_s   = pass_idx_r;
            end
            default: begin
                which_nxt_s      = {FW{1'b0}};
                slot_valid_nxt_s = {SLOTS{1'b0}};
                pass_idx_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

`ifdef DECODER_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_r;
    logic           err_r;

    // Counts cycles since the pass was issued; timeout is judged only in WAIT.
    assign timeout_s = (state_r == WAIT) && !dec_out_valid && (wd_cnt_r == WDW'(WD_CYCLES - 1));

    // Watchdog counter restarts at each issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= {WDW{1'b0}};
        end else if (state_nxt_s == ISSUE) begin
            wd_cnt_r <= {WDW{1'b0}};
        end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
            wd_cnt_r <= wd_cnt_r + WDW'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky error, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    assign busy             = busy_r;
    assign done             = done_r;
    assign dec_in_valid     = in_valid_r;
    assign dec_which_filter = which_r;
    assign slot_valid       = slot_valid_r;
    assign pass_idx         = pass_idx_r;
    assign acc_valid        = acc_valid_r;
    assign acc_last         = acc_last_r;

endmodule

// File: tb/tb_decoder_sched.sv
// Self-checking bench for decoder_sched: directed and randomized jobs against a
// pass-level reference model (filter index = pass*SLOTS + slot, clamped count).
module tb_decoder_sched;

    localparam int NM = 2;
    localparam int MF = 4;
    localparam int OC = 64;
    localparam int SL = NM * MF;
    localparam int BW = 6;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   cfg_num_filter = '0;
    logic            busy, done, dec_in_valid, acc_valid, acc_last, err;
    logic [SL*BW-1:0] dec_which_filter;
    logic            dec_out_valid = 1'b0;
    logic [SL-1:0]   slot_valid;
    logic [CW-1:0]   pass_idx;
    logic            acc_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    decoder_sched #(
        .NUM_MACRO(NM), .MAX_NUM_FILTER(MF), .OUT_CH(OC), .WD_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_filter(cfg_num_filter),
        .busy(busy), .done(done), .dec_in_valid(dec_in_valid),
        .dec_which_filter(dec_which_filter), .dec_out_valid(dec_out_valid),
        .slot_valid(slot_valid), .pass_idx(pass_idx), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_last(acc_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SL*BW-1:0] exp_fields(input int n, input int p);
        logic [SL*BW-1:0] v;
        int f;
        v = '0;
        for (int s = 0; s < SL; s++) begin
            f = p * SL + s;
            if (f < n) v[s*BW +: BW] = f[BW-1:0];
        end
        return v;
    endfunction

    function automatic logic [SL-1:0] exp_valid(input int n, input int p);
        logic [SL-1:0] v;
        v = '0;
        for (int s = 0; s < SL; s++) v[s] = ((p * SL + s) < n);
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_in_valid"}, 64'(dec_in_valid), 64'd0);
        chk({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
        chk({tag, "_acc_last"}, 64'(acc_last), 64'd0);
        chk({tag, "_fields"}, 64'(dec_which_filter), 64'd0);
        chk({tag, "_slot_valid"}, 64'(slot_valid), 64'd0);
        chk({tag, "_pass_idx"}, 64'(pass_idx), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // One job: start at the current negedge, then track the expected handshakes.
    task automatic run_job(input int cfg, input int pct, input int dly, input int hold_pass, input bit timing);
        int n, np, p, wcnt, hold, cyc;
        bit e_issue, e_acc, e_done, n_issue, n_acc, n_done, fin, rdy;
        n = (cfg > OC) ? OC : cfg;
        np = (n + SL - 1) / SL;
        p = 0; wcnt = 0; hold = 0; fin = 1'b0;
        start = 1'b1;
        cfg_num_filter = CW'(cfg);
        @(negedge clk);
        start = 1'b0;
        e_issue = (n > 0); e_acc = 1'b0; e_done = (n == 0);
        for (cyc = 1; cyc <= 400 && !fin; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 1) chk("err_after_start", 64'(err), 64'd0);
            chk("dec_in_valid", 64'(dec_in_valid), 64'(e_issue));
            chk("acc_valid", 64'(acc_valid), 64'(e_acc));
            chk("done", 64'(done), 64'(e_done));
            chk("busy", 64'(busy), 64'(!e_done));
            if (e_issue) begin
                chk("issue_fields", 64'(dec_which_filter), 64'(exp_fields(n, p)));
                chk("issue_slot_valid", 64'(slot_valid), 64'(exp_valid(n, p)));
                chk("issue_pass_idx", 64'(pass_idx), 64'(p));
            end
            if (e_acc) begin
                chk("acc_last", 64'(acc_last), 64'(p == np - 1));
                chk("acc_pass_idx", 64'(pass_idx), 64'(p));
                chk("acc_fields", 64'(dec_which_filter), 64'(exp_fields(n, p)));
                chk("acc_slot_valid", 64'(slot_valid), 64'(exp_valid(n, p)));
            end
            if (e_done) begin
                chk("done_pass_count", 64'(p), 64'(np));
                chk("done_fields_clear", 64'(dec_which_filter), 64'd0);
                chk("done_pass_idx_clear", 64'(pass_idx), 64'd0);
                chk("done_err", 64'(err), 64'd0);
                if (timing) chk("done_latency", 64'(cyc), 64'((n == 0) ? 1 : 3 * np + 1));
                fin = 1'b1;
            end
            n_issue = 1'b0; n_acc = e_acc; n_done = 1'b0;
            if (e_issue) begin
                wcnt = dly;
                dec_out_valid = 1'($urandom_range(0, 1));
            end else if (wcnt > 0) begin
                wcnt--;
                dec_out_valid = (wcnt == 0);
                if (wcnt == 0) n_acc = 1'b1;
            end else begin
                dec_out_valid = 1'($urandom_range(0, 1));
            end
            if (e_acc) begin
                if (p == hold_pass && hold < 5) begin
                    rdy = 1'b0;
                    hold++;
                end else begin
                    rdy = ($urandom_range(1, 100) <= pct);
                end
                acc_ready = rdy;
                if (rdy) begin
                    n_acc = 1'b0;
                    if (p == np - 1) n_done = 1'b1;
                    else n_issue = 1'b1;
                    p++;
                end
            end else begin
                acc_ready = 1'($urandom_range(0, 1));
            end
            start = busy && ($urandom_range(0, 3) == 0);
            e_issue = n_issue; e_acc = n_acc; e_done = n_done;
        end
        if (!fin) chk("job_completes", 64'd0, 64'd1);
        start = 1'b0; dec_out_valid = 1'b0; acc_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(20, 100, 1, -1, 1'b1);
        run_job(0, 100, 1, -1, 1'b1);
        run_job(100, 100, 1, -1, 1'b1);
        run_job(20, 100, 1, 1, 1'b0);

        // Reset asserted while the scheduler waits on the decoder.
        start = 1'b1;
        cfg_num_filter = CW'(20);
        @(negedge clk);
        start = 1'b0;
        dec_out_valid = 1'b0;
        chk("rst_pre_in_valid", 64'(dec_in_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midjob_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_done", 64'(done), 64'd0);
            chk("post_reset_busy", 64'(busy), 64'd0);
        end

`ifdef DECODER_WATCHDOG_EN
        begin
            int icyc, dcyc, iss;
            icyc = -1; dcyc = -1; iss = 0;
            start = 1'b1;
            cfg_num_filter = CW'(8);
            @(negedge clk);
            start = 1'b0;
            dec_out_valid = 1'b0;
            acc_ready = 1'b0;
            for (int c = 1; c <= 60 && dcyc < 0; c++) begin
                if (c > 1) @(negedge clk);
                if (dec_in_valid) begin
                    iss++;
                    icyc = c;
                end
                if (done) begin
                    dcyc = c;
                    chk("wd_err_at_done", 64'(err), 64'd1);
                    chk("wd_acc_valid", 64'(acc_valid), 64'd0);
                end
            end
            chk("wd_issue_count", 64'(iss), 64'd1);
            chk("wd_done_latency", 64'(dcyc - icyc), 64'd16);
            @(negedge clk);
            chk("wd_err_sticky", 64'(err), 64'd1);
            run_job(8, 100, 1, -1, 1'b1);
        end
`endif

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 80)), int'($urandom_range(30, 100)),
                    int'($urandom_range(1, 3)), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
